// File: rtl/filename_stream.sv
// Streams the ASCII name "IMG_<tens><units>.BMP" byte by byte over a valid/ready handshake.
// Optional feature macro: FILENAME_NUL_TERM_EN appends a 0x00 terminator that carries byte_last.
module filename_stream #(
    parameter int LEADING_ZERO = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bcd,
    output logic       busy,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       done,
    output logic       bcd_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

`ifdef FILENAME_NUL_TERM_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif
    localparam logic DROP_ZERO_TENS = (LEADING_ZERO == 32'sd0);

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        logic [7:0] c;
        if (d > 4'd9) begin
            c = 8'h3F;
        end else begin
            c = {4'h3, d};
        end
        return c;
    endfunction

    function automatic logic digit_bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    // Index 10 only exists with the terminator and falls to the 0x00 default.
    function automatic logic [7:0] byte_at(input logic [3:0] idx, input logic [7:0] b);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'h49;
            4'd1:    c = 8'h4D;
            4'd2:    c = 8'h47;
            4'd3:    c = 8'h5F;
            4'd4:    c = digit_ascii(b[7:4]);
            4'd5:    c = digit_ascii(b[3:0]);
            4'd6:    c = 8'h2E;
            4'd7:    c = 8'h42;
            4'd8:    c = 8'h4D;
            4'd9:    c = 8'h50;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_t     r_state;
    logic [3:0] r_idx;
    logic [7:0] r_bcd;
    logic       r_err;
    logic       r_busy;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_last;
    logic       r_done;

    state_t     w_state_nxt;
    logic [3:0] w_idx_nxt;
    logic [7:0] w_bcd_nxt;
    logic       w_err_nxt;
    logic       w_done_nxt;
    logic       w_hs;

    // Next-state, byte index advance and latch decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bcd_nxt   = r_bcd;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        w_hs        = r_valid & byte_ready;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = EMIT;
                    w_idx_nxt   = 4'd0;
                    w_bcd_nxt   = bcd;
                    w_err_nxt   = digit_bad(bcd);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EMIT: begin
                if (w_hs) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = 4'd0;
                        w_done_nxt  = 1'b1;
                    end else if ((r_idx == 4'd3) && DROP_ZERO_TENS && (r_bcd[7:4] == 4'd0)) begin
                        w_idx_nxt = 4'd5;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // State and output registers; outputs are precomputed from next-state so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_bcd   <= 8'h00;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bcd   <= w_bcd_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt == EMIT);
            r_valid <= (w_state_nxt == EMIT);
            r_data  <= (w_state_nxt == EMIT) ? byte_at(w_idx_nxt, w_bcd_nxt) : 8'h00;
            r_last  <= (w_state_nxt == EMIT) && (w_idx_nxt == LAST_IDX);
            r_done  <= w_done_nxt;
        end
    end

    assign busy       = r_busy;
    assign byte_data  = r_data;
    assign byte_valid = r_valid;
    assign byte_last  = r_last;
    assign done       = r_done;
    assign bcd_err    = r_err;

endmodule

// File: tb/tb_filename_stream.sv
// Randomized bench for filename_stream: two instances (LEADING_ZERO=1 and 0) checked
// against a string-level reference model of the expected filename.
module tb_filename_stream;

    typedef logic [7:0] q8_t[$];

    logic            clk;
    logic            reset;
    logic [1:0]      start_v;
    logic [1:0][7:0] bcd_v;
    logic [1:0]      rdy_v;
    logic [1:0]      busy_v;
    logic [1:0][7:0] data_v;
    logic [1:0]      valid_v;
    logic [1:0]      last_v;
    logic [1:0]      done_v;
    logic [1:0]      err_v;

    int n_checks = 0;
    int n_errors = 0;

    filename_stream #(.LEADING_ZERO(1)) u_lz1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .bcd(bcd_v[0]),
        .busy(busy_v[0]), .byte_data(data_v[0]), .byte_valid(valid_v[0]),
        .byte_ready(rdy_v[0]), .byte_last(last_v[0]), .done(done_v[0]), .bcd_err(err_v[0])
    );

    filename_stream #(.LEADING_ZERO(0)) u_lz0 (
        .clk(clk), .reset(reset), .start(start_v[1]), .bcd(bcd_v[1]),
        .busy(busy_v[1]), .byte_data(data_v[1]), .byte_valid(valid_v[1]),
        .byte_ready(rdy_v[1]), .byte_last(last_v[1]), .done(done_v[1]), .bcd_err(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] digit_char(input int d);
        if (d > 9) return 8'h3F;
        return 8'h30 + 8'(d);
    endfunction

    // Reference: the filename as a list of characters built from the naming rules.
    function automatic q8_t exp_name(input logic [7:0] b, input bit keep_zero);
        q8_t q;
        int tens;
        int units;
        tens  = int'(b[7:4]);
        units = int'(b[3:0]);
        q = {8'h49, 8'h4D, 8'h47, 8'h5F};
        if (keep_zero || tens != 0) q.push_back(digit_char(tens));
        q.push_back(digit_char(units));
        q.push_back(8'h2E); q.push_back(8'h42); q.push_back(8'h4D); q.push_back(8'h50);
`ifdef FILENAME_NUL_TERM_EN
        q.push_back(8'h00);
`endif
        return q;
    endfunction

    function automatic logic pick_ready(input int mode, input int t);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((t % 4) == 0) || ((t % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at a negedge; drives start immediately so back-to-back names start in the done cycle.
    task automatic run_name(input int sel, input logic [7:0] b, input int mode, input int abort_after);
        q8_t        exp_q;
        int         k;
        int         cyc;
        int         tog;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       hs;
        logic       exp_err;
        bit         aborted;
        exp_q      = exp_name(b, sel == 0);
        exp_err    = (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
        start_v[sel] = 1'b1;
        bcd_v[sel]   = b;
        rdy_v[sel]   = 1'b0;
        @(negedge clk);
        start_v[sel] = 1'b0;
        bcd_v[sel]   = 8'($urandom);
        check("first_valid", 32'(valid_v[sel]), 32'd1);
        check("busy_emit", 32'(busy_v[sel]), 32'd1);
        check("done_low", 32'(done_v[sel]), 32'd0);
        check("bcd_err", 32'(err_v[sel]), 32'(exp_err));
        k = 0; cyc = 0; tog = 0; prev_stall = 1'b0; prev_data = 8'h00; aborted = 1'b0;
        while (k < exp_q.size() && cyc < 200) begin
            if (prev_stall) check("stall_stable", 32'(data_v[sel]), 32'(prev_data));
            check("valid_hold", 32'(valid_v[sel]), 32'd1);
            rdy_v[sel]   = pick_ready(mode, tog);
            tog++;
            start_v[sel] = ($urandom_range(0, 3) == 0);
            bcd_v[sel]   = 8'($urandom);
            hs = valid_v[sel] && rdy_v[sel];
            if (hs) begin
                check("byte", 32'(data_v[sel]), 32'(exp_q[k]));
                check("last", 32'(last_v[sel]), 32'(k == exp_q.size() - 1));
                k++;
            end
            prev_stall = valid_v[sel] && !rdy_v[sel];
            prev_data  = data_v[sel];
            @(negedge clk);
            cyc++;
            if (abort_after != 0 && k == abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        start_v[sel] = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            #1;
            check("rst_valid", 32'(valid_v[sel]), 32'd0);
            check("rst_busy", 32'(busy_v[sel]), 32'd0);
            check("rst_data", 32'(data_v[sel]), 32'd0);
            check("rst_err", 32'(err_v[sel]), 32'd0);
            repeat (2) begin
                @(negedge clk);
                check("rst_no_done", 32'(done_v[sel]), 32'd0);
            end
            reset = 1'b0;
        end else if (k < exp_q.size()) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("done_pulse", 32'(done_v[sel]), 32'd1);
            check("valid_off", 32'(valid_v[sel]), 32'd0);
            check("busy_off", 32'(busy_v[sel]), 32'd0);
            check("idle_data", 32'(data_v[sel]), 32'd0);
            check("idle_last", 32'(last_v[sel]), 32'd0);
            check("err_sticky", 32'(err_v[sel]), 32'(exp_err));
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         sel;
        reset   = 1'b1;
        start_v = 2'b00;
        bcd_v   = '0;
        rdy_v   = 2'b00;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_valid", 32'(valid_v[i]), 32'd0);
            check("reset_data", 32'(data_v[i]), 32'd0);
            check("reset_busy", 32'(busy_v[i]), 32'd0);
            check("reset_done", 32'(done_v[i]), 32'd0);
            check("reset_err", 32'(err_v[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("no_valid_pre_start", 32'(valid_v[0] | valid_v[1]), 32'd0);

        run_name(0, 8'h42, 0, 0);
        run_name(1, 8'h07, 0, 0);
        run_name(0, 8'h07, 0, 0);
        run_name(0, 8'h99, 1, 0);
        run_name(0, 8'hA3, 0, 0);
        run_name(0, 8'h12, 0, 0);
        run_name(1, 8'hA3, 2, 5);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 32'(valid_v[1]), 32'd0);
        end
        run_name(1, 8'h55, 0, 0);
        run_name(0, 8'hA3, 2, 5);
        repeat (2) @(negedge clk);
        run_name(0, 8'h01, 0, 0);

        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 1));
            rb  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) rb[7:4] = 4'd0;
            run_name(sel, rb, int'($urandom_range(0, 2)), 0);
            if ($urandom_range(0, 1) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
